// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_pkg;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Sequencer states: accept, optional wait, one-cycle memory access, response hold.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant. Bit 0 is the IFU, bit 1 is the LSU.
// A lone requester always wins; on a tie the port that did not win last is chosen.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    owner_t last_grant_reg;

    // Combinational grant from the current requests and the previous winner
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_reg == OWN_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when its request is actually taken
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_reg <= OWN_LSU;
        end else if (accept) begin
            last_grant_reg <= grant[1] ? OWN_LSU : OWN_IFU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing a combinational-read memory between the IFU
// (read-only) and the LSU (read/write). One transaction in flight at a time;
// each memory strobe is high for exactly one cycle so a side-effecting model
// behind the memory port sees every access once.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_ren,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata
);

    localparam int MASK_W = DATA_W / 8;
    // Counter never narrower than one bit, even when no wait cycles are used.
    localparam int CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t              state_reg;
    owner_t              owner_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                wen_reg;
    logic [MASK_W-1:0]   wmask_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   data_reg;

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                accept;
    logic                owner_resp_ready;
    logic                in_access;
    logic                in_resp;

    // Requests are only visible to the arbiter while idle, so ready is low elsewhere.
    assign req           = (state_reg == IDLE) ? {lsu_req_valid, ifu_req_valid} : 2'b00;
    assign ifu_req_ready = grant[0];
    assign lsu_req_ready = grant[1];
    assign accept        = |(req & grant);

    assign owner_resp_ready = (owner_reg == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign in_access        = (state_reg == ACCESS);
    assign in_resp          = (state_reg == RESP);

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // Sequencer: latch the winning request, wait, access once, hold the response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= OWN_IFU;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wmask_reg <= '0;
            wdata_reg <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        owner_reg <= grant[1] ? OWN_LSU : OWN_IFU;
                        addr_reg  <= grant[1] ? lsu_req_addr : ifu_req_addr;
                        wen_reg   <= grant[1] & lsu_req_wen;
                        wmask_reg <= grant[1] ? lsu_req_wmask : '0;
                        wdata_reg <= grant[1] ? lsu_req_wdata : '0;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= (LATENCY > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    // Write acks carry zero data; reads capture the combinational memory output.
                    data_reg  <= wen_reg ? '0 : mem_rdata;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory port is driven only during the single access cycle, quiet otherwise
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (in_access) begin
            mem_addr = addr_reg;
            mem_ren  = ~wen_reg;
            mem_wen  = wen_reg;
            if (wen_reg) begin
                mem_wmask = wmask_reg;
                mem_wdata = wdata_reg;
            end
        end
    end

    // Response goes only to the transaction owner; the other port sees zeros
    always_comb begin
        ifu_resp_valid = in_resp && (owner_reg == OWN_IFU);
        lsu_resp_valid = in_resp && (owner_reg == OWN_LSU);
        ifu_resp_data  = ifu_resp_valid ? data_reg : '0;
        lsu_resp_data  = lsu_resp_valid ? data_reg : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter, run on two latency settings in parallel.
// The reference predicts timing from the latency formula and data from a
// word-array memory image updated by the bench's own request stream.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt  = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Initial memory image; two words preloaded with known contents.
    function automatic logic [63:0] init_val(input int idx);
        if (idx == 0)      return 64'h00000413_00000297;
        if (idx == 'h200)  return 64'h11223344_55667788;
        return {32'(idx) ^ 32'hA5A5_0000, 32'(idx) * 32'h9E37_79B9};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_addr();
        return 64'h8000_0000 + 64'($urandom_range(0, 31)) * 64'd8;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lat
            localparam int LAT = (gi == 0) ? 0 : 3;

            logic        rst;
            logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
            logic [63:0] ifu_req_addr, ifu_resp_data;
            logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
            logic [7:0]  lsu_req_wmask;
            logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
            logic        mem_ren, mem_wen;
            logic [63:0] mem_addr, mem_rdata, mem_wdata;
            logic [7:0]  mem_wmask;

            logic [63:0] env_mem     [0:8191];
            bit          env_written [0:8191];
            logic [63:0] ref_mem     [0:8191];
            int          wen_cnt = 0;
            bit          exp_last;   // 1 = LSU won the last accepted request

            mem_arbiter #(.LATENCY(LAT), .ADDR_W(64), .DATA_W(64)) u_dut (
                .clock          (clk),
                .reset          (rst),
                .ifu_req_valid  (ifu_req_valid),
                .ifu_req_ready  (ifu_req_ready),
                .ifu_req_addr   (ifu_req_addr),
                .ifu_resp_valid (ifu_resp_valid),
                .ifu_resp_ready (ifu_resp_ready),
                .ifu_resp_data  (ifu_resp_data),
                .lsu_req_valid  (lsu_req_valid),
                .lsu_req_ready  (lsu_req_ready),
                .lsu_req_addr   (lsu_req_addr),
                .lsu_req_wen    (lsu_req_wen),
                .lsu_req_wmask  (lsu_req_wmask),
                .lsu_req_wdata  (lsu_req_wdata),
                .lsu_resp_valid (lsu_resp_valid),
                .lsu_resp_ready (lsu_resp_ready),
                .lsu_resp_data  (lsu_resp_data),
                .mem_ren        (mem_ren),
                .mem_addr       (mem_addr),
                .mem_rdata      (mem_rdata),
                .mem_wen        (mem_wen),
                .mem_wmask      (mem_wmask),
                .mem_wdata      (mem_wdata)
            );

            // Combinational-read memory seen by the DUT
            always_comb begin
                mem_rdata = 64'h0;
                if (mem_ren) begin
                    mem_rdata = env_written[mem_addr[15:3]] ? env_mem[mem_addr[15:3]]
                                                            : init_val(int'(mem_addr[15:3]));
                end
            end

            // Memory write port plus a count of write strobes
            always @(posedge clk) begin
                if (mem_wen) begin
                    env_mem[mem_addr[15:3]] <= merge(env_written[mem_addr[15:3]] ? env_mem[mem_addr[15:3]]
                                                     : init_val(int'(mem_addr[15:3])), mem_wdata, mem_wmask);
                    env_written[mem_addr[15:3]] <= 1'b1;
                    wen_cnt <= wen_cnt + 1;
                end
            end

            // One complete transaction from request to response handshake.
            // both: the other port is held valid too (caller picks the expected winner).
            task automatic run_txn(input bit is_lsu, input logic [63:0] addr, input bit wen,
                                   input logic [7:0] wmask, input logic [63:0] wdata,
                                   input int stall, input bit both, input bit scramble);
                logic [63:0] exp_data;
                bit          is_wr;
                int          idx;
                int          waited;
                is_wr = is_lsu && wen;
                idx   = int'(addr[15:3]);
                if (is_lsu) begin
                    lsu_req_valid = 1'b1;
                    lsu_req_addr  = addr;
                    lsu_req_wen   = wen;
                    lsu_req_wmask = wmask;
                    lsu_req_wdata = wdata;
                    ifu_req_valid = both;
                    ifu_req_addr  = rand_addr();
                end else begin
                    ifu_req_valid = 1'b1;
                    ifu_req_addr  = addr;
                    lsu_req_valid = both;
                    lsu_req_addr  = rand_addr();
                    lsu_req_wen   = 1'($urandom_range(0, 1));
                    lsu_req_wmask = 8'($urandom);
                    lsu_req_wdata = {$urandom, $urandom};
                end
                #1;
                waited = 0;
                while (!(is_lsu ? lsu_req_ready : ifu_req_ready) && waited < 20) begin
                    @(negedge clk);
                    #1;
                    waited++;
                end
                check("accept_delay", 64'(waited), 64'd0);
                check("grant", 64'({ifu_req_ready, lsu_req_ready}), is_lsu ? 64'd1 : 64'd2);
                if (is_wr) begin
                    ref_mem[idx] = merge(ref_mem[idx], wdata, wmask);
                    exp_data = 64'h0;
                end else begin
                    exp_data = ref_mem[idx];
                end
                exp_last = is_lsu;
                @(posedge clk);
                @(negedge clk);
                if (!both) begin
                    if (is_lsu) lsu_req_valid = 1'b0;
                    else        ifu_req_valid = 1'b0;
                end
                if (scramble) begin
                    lsu_req_addr  = rand_addr();
                    lsu_req_wdata = {$urandom, $urandom};
                    lsu_req_wmask = 8'($urandom);
                    lsu_req_wen   = 1'($urandom_range(0, 1));
                    ifu_req_addr  = rand_addr();
                end
                // Cycles 1 .. 1+LAT: only the last one carries the strobe
                for (int j = 1; j <= LAT + 1; j++) begin
                    #1;
                    check("ready_busy", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
                    check("resp_early", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
                    check("mem_ren", 64'(mem_ren), 64'((j == LAT + 1) && !is_wr));
                    check("mem_wen", 64'(mem_wen), 64'((j == LAT + 1) && is_wr));
                    if (j == LAT + 1) begin
                        check("mem_addr", mem_addr, addr);
                        if (is_wr) begin
                            check("mem_wmask", 64'(mem_wmask), 64'(wmask));
                            check("mem_wdata", mem_wdata, wdata);
                        end
                    end
                    @(negedge clk);
                end
                // Response held for 'stall' cycles, then consumed
                for (int s = 0; s <= stall; s++) begin
                    if (is_lsu) lsu_resp_ready = (s == stall);
                    else        ifu_resp_ready = (s == stall);
                    #1;
                    check("resp_valid", 64'(is_lsu ? lsu_resp_valid : ifu_resp_valid), 64'd1);
                    check("resp_data", is_lsu ? lsu_resp_data : ifu_resp_data, exp_data);
                    check("resp_other", 64'(is_lsu ? ifu_resp_valid : lsu_resp_valid), 64'd0);
                    check("ready_resp", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
                    check("mem_quiet", 64'({mem_ren, mem_wen}), 64'd0);
                    @(negedge clk);
                end
                ifu_resp_ready = 1'b0;
                lsu_resp_ready = 1'b0;
                #1;
                check("resp_done", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
                check("next_ready", 64'({ifu_req_ready, lsu_req_ready}),
                      both ? (is_lsu ? 64'd2 : 64'd1) : 64'd0);
                $display("lat=%0d %s %s addr=%h data=%h stall=%0d both=%0d",
                         LAT, is_lsu ? "LSU" : "IFU", is_wr ? "WR" : "RD", addr,
                         is_wr ? wdata : exp_data, stall, both);
            endtask

            // Reset pulsed one cycle after an LSU write is accepted
            task automatic reset_test();
                int base;
                lsu_req_valid = 1'b1;
                lsu_req_addr  = 64'h8000_0040;
                lsu_req_wen   = 1'b1;
                lsu_req_wmask = 8'hFF;
                lsu_req_wdata = 64'h0123_4567_89AB_CDEF;
                ifu_req_valid = 1'b0;
                #1;
                check("rst_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'd1);
                base = wen_cnt;
                @(posedge clk);
                @(negedge clk);
                lsu_req_valid = 1'b0;
                #1;
                check("rst_strobe", 64'(mem_wen), 64'(LAT == 0));
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("rst_outs", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                                        lsu_resp_valid, mem_ren, mem_wen}), 64'd0);
                check("rst_addr", mem_addr, 64'd0);
                for (int k = 0; k < LAT + 3; k++) begin
                    check("rst_quiet", 64'({mem_ren, mem_wen, ifu_resp_valid, lsu_resp_valid}), 64'd0);
                    @(negedge clk);
                    #1;
                end
                // Only the access cycle can still reach the memory when reset lands on it.
                check("rst_wen_count", 64'(wen_cnt - base), 64'(LAT == 0));
                if (LAT == 0) ref_mem[8] = merge(ref_mem[8], 64'h0123_4567_89AB_CDEF, 8'hFF);
                exp_last = 1'b1;
                $display("lat=%0d reset during in-flight LSU write", LAT);
            endtask

            initial begin
                bit          r_both, r_lsu, r_wen;
                logic [63:0] r_addr;
                for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
                rst            = 1'b1;
                ifu_req_valid  = 1'b0;
                ifu_req_addr   = 64'h0;
                ifu_resp_ready = 1'b0;
                lsu_req_valid  = 1'b0;
                lsu_req_addr   = 64'h0;
                lsu_req_wen    = 1'b0;
                lsu_req_wmask  = 8'h0;
                lsu_req_wdata  = 64'h0;
                lsu_resp_ready = 1'b0;
                exp_last       = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                #1;
                check("reset_outs", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                                          lsu_resp_valid, mem_ren, mem_wen}), 64'd0);
                check("reset_data", ifu_resp_data | lsu_resp_data | mem_addr | mem_wdata, 64'd0);
                check("reset_mask", 64'(mem_wmask), 64'd0);
                @(negedge clk);

                // Known-content IFU fetch, then masked LSU write and read-back
                run_txn(1'b0, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 0, 1'b0, 1'b0);
                run_txn(1'b1, 64'h8000_1000, 1'b1, 8'h0F, 64'hDEADBEEF_CAFEBABE, 0, 1'b0, 1'b0);
                run_txn(1'b1, 64'h8000_1000, 1'b0, 8'h00, 64'h0, 0, 1'b0, 1'b0);

                // Both requesters continuously valid: winners alternate
                for (int k = 0; k < 4; k++) begin
                    run_txn(!exp_last, rand_addr(), 1'b0, 8'h00, 64'h0, 0, 1'b1, 1'b0);
                end
                // Long response stall with the other port waiting
                run_txn(!exp_last, 64'h8000_0010, 1'b0, 8'h00, 64'h0, 5, 1'b1, 1'b0);
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                // Request fields changed right after acceptance
                run_txn(1'b1, 64'h8000_0018, 1'b1, 8'hF0, 64'h5555_6666_7777_8888, 1, 1'b0, 1'b1);
                run_txn(1'b1, 64'h8000_0018, 1'b0, 8'h00, 64'h0, 0, 1'b0, 1'b1);

                reset_test();
                run_txn(!exp_last, 64'h8000_0040, 1'b0, 8'h00, 64'h0, 0, 1'b1, 1'b0);
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;

                for (int n = 0; n < 40; n++) begin
                    r_both = 1'($urandom_range(0, 1));
                    r_lsu  = r_both ? !exp_last : 1'($urandom_range(0, 1));
                    r_wen  = 1'($urandom_range(0, 1));
                    r_addr = rand_addr();
                    run_txn(r_lsu, r_addr, r_wen, 8'($urandom), {$urandom, $urandom},
                            $urandom_range(0, 3), r_both, 1'($urandom_range(0, 1)));
                end
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                done_cnt++;
            end
        end
    endgenerate

    initial begin
        fork
            wait (done_cnt == 2);
            #2_000_000;
        join_any
        check("finished", 64'(done_cnt), 64'd2);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
